// File: rtl/bus_transfer_sequencer_if.sv
// Register-bus transfer interface: four requesters, one-hot register enables.
// Build option: BUS_ROUND_ROBIN_EN changes the sequencer's arbitration only.
// The master modport is the sequencer; the slave modport is the requester/register side.
interface bus_transfer_sequencer_if #(
  parameter int NUM_REGS = 8
);
  logic [3:0]          req;
  logic [11:0]         req_src;
  logic [11:0]         req_dst;
  logic [NUM_REGS-1:0] bus_out_en;
  logic [NUM_REGS-1:0] bus_in_en;
  logic [3:0]          grant;
  logic                err;
  logic                busy;

  modport master (
    input  req, req_src, req_dst,
    output bus_out_en, bus_in_en, grant, err, busy
  );

  modport slave (
    output req, req_src, req_dst,
    input  bus_out_en, bus_in_en, grant, err, busy
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Register-to-register bus transfer sequencer for four requesters.
// Latency: 4 cycles per valid transfer (arbitrate, drive, latch, done); 2 cycles per rejected transfer.
// Backpressure: requests wait unacknowledged while busy. BUS_ROUND_ROBIN_EN selects round-robin arbitration.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int ID_W     = 3
) (
  input logic                    register_clock,
  input logic                    register_reset,
  bus_transfer_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

  localparam logic [31:0] NREG_U = NUM_REGS;

  state_t          state_q, state_d;
  logic [ID_W-1:0] src_q, dst_q;
  logic [ID_W-1:0] cand_src, cand_dst;
  logic [1:0]      sel_q;
  logic [1:0]      pick;
  logic            rej_q;
  logic            cand_rej;
  logic            any_req;
  logic            capture;

  assign any_req = |bus.req;
  assign capture = (state_q == IDLE) && any_req;

`ifdef BUS_ROUND_ROBIN_EN
  // ptr_q holds the last requester served; reset value 3 makes requester 0 first in line.
  logic [1:0] ptr_q;
  logic       rr_found;

  // Round-robin pick: scan starting just after the last served requester, wrapping 3 -> 0.
  always_comb begin
    pick     = 2'd0;
    rr_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!rr_found && bus.req[ptr_q + 2'(k + 1)]) begin
        pick     = ptr_q + 2'(k + 1);
        rr_found = 1'b1;
      end
    end
  end

  // Advance the pointer whenever a requester is captured, rejected or not.
  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      ptr_q <= 2'd3;
    end else if (capture) begin
      ptr_q <= pick;
    end
  end
`else
  // Fixed-priority pick: lowest-numbered active requester wins.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick = 2'(i);
      end
    end
  end
`endif

  // Candidate IDs of the picked requester and the reject decision for them.
  always_comb begin
    cand_src = bus.req_src[ID_W*pick +: ID_W];
    cand_dst = bus.req_dst[ID_W*pick +: ID_W];
    cand_rej = (cand_src == cand_dst) ||
               (32'(cand_src) >= NREG_U) ||
               (32'(cand_dst) >= NREG_U);
  end

  // State register plus the transfer context, frozen at capture for the whole transfer.
  always_ff @(posedge register_clock) begin
    if (register_reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      sel_q   <= 2'd0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        src_q <= cand_src;
        dst_q <= cand_dst;
        sel_q <= pick;
        rej_q <= cand_rej;
      end
    end
  end

  // Next state: rejected transfers skip straight to DONE so only grant/err are seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = cand_rej ? DONE : DRIVE;
      DRIVE:   state_d = LATCH;
      LATCH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: enables decoded from the held IDs, so at most one driver is ever on.
  always_comb begin
    bus.bus_out_en = '0;
    bus.bus_in_en  = '0;
    bus.grant      = 4'b0000;
    bus.err        = 1'b0;
    bus.busy       = (state_q != IDLE);
    case (state_q)
      DRIVE: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          bus.bus_out_en[i] = (src_q == ID_W'(i));
        end
      end
      LATCH: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          bus.bus_out_en[i] = (src_q == ID_W'(i));
          bus.bus_in_en[i]  = (dst_q == ID_W'(i));
        end
      end
      DONE: begin
        bus.grant[sel_q] = 1'b1;
        bus.err          = rej_q;
      end
      default: ;
    endcase
  end

endmodule
